// File: rtl/mem_responder_if.sv
// Request/response bus between a requester and the register responder.
// Latency: none, wires only.
// Backpressure: valid/ready on both the request and the response channel.
interface mem_responder_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_error;

  // Requester side drives requests and accepts responses.
  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  // Responder side accepts requests and drives responses.
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-mapped register responder: one request at a time, read/write on a register array.
// Latency: rsp_valid rises WAIT_CYCLES+2 edges after the request handshake.
// Backpressure: response held stable until rsp_ready; no new request accepted meanwhile.
// Optional MEM_RESPONDER_ADDR_ERR_EN: flag out-of-range addresses on rsp_error.
module mem_responder #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 4,
  parameter int DEPTH       = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);
  localparam logic [7:0]      WAIT_V  = 8'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  req_t              req_q, req_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              error_q, error_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_word;
  logic              err_hit;

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_error = error_q;

  // Decode the latched address: range check and array read for the access stage.
  always_comb begin
    in_range = ({1'b0, req_q.addr} < DEPTH_V);
    idx      = req_q.addr[IDX_W-1:0];
    rd_word  = '0;
    if (in_range) begin
      rd_word = mem[idx];
    end
`ifdef MEM_RESPONDER_ADDR_ERR_EN
    err_hit = !in_range;
`else
    err_hit = 1'b0;
`endif
  end

  // Next-state and output logic; rsp_valid rises one edge after the access executes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    ready_d = ready_q;
    valid_d = valid_q;
    rdata_d = rdata_q;
    error_d = error_q;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ready_q && bus.req_valid) begin
          req_d.write = bus.req_write;
          req_d.addr  = bus.req_addr;
          req_d.wdata = bus.req_wdata;
          cnt_d       = WAIT_V;
          ready_d     = 1'b0;
          state_d     = S_WAIT;
        end else begin
          ready_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt_q == 8'd0) begin
          mem_we  = req_q.write && in_range;
          rdata_d = req_q.write ? '0 : rd_word;
          error_d = err_hit;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_RESP: begin
        if (!valid_q) begin
          valid_d = 1'b1;
        end else if (bus.rsp_ready) begin
          valid_d = 1'b0;
          rdata_d = '0;
          error_d = 1'b0;
          ready_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  // Register array; written only on the access edge of an in-range write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (mem_we) begin
      mem[idx] <= req_q.wdata;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: reset, latency, backpressure, range, mid-op reset, streaming.
// Latency: WAIT_CYCLES=2 instance for most tests, WAIT_CYCLES=0 instance for back-to-back.
// Backpressure: rsp_ready held low on one read to exercise response hold.
module tb_mem_responder;
  localparam int DW = 32;
  localparam int AW = 4;

`ifdef MEM_RESPONDER_ADDR_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mem_responder_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  mem_responder_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();

  mem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(12), .WAIT_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(12), .WAIT_CYCLES(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction on the WAIT_CYCLES=2 instance with rsp_ready high.
  task automatic do_txn(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output logic [DW-1:0] rd, output logic er, output int lat);
    int n;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_valid = 1'b1;
    bus.rsp_ready = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus.req_ready) chk("req_ready_timeout", 64'd0, 64'd1);
    tick();
    bus.req_valid = 1'b0;
    bus.req_write = 1'b1;
    bus.req_addr  = '1;
    bus.req_wdata = '1;
    lat = 0;
    while (!bus.rsp_valid && lat < 50) begin
      tick();
      lat++;
    end
    rd = bus.rsp_rdata;
    er = bus.rsp_error;
    tick();
    chk("rsp_valid_drop", bus.rsp_valid, 0);
    chk("req_ready_back", bus.req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] rd;
    logic          er;
    int            lat;
    int            n;
    logic          seen;
    logic [DW-1:0] hold_d;
    logic          hold_e;
    logic          bw [8];
    logic [AW-1:0] ba [8];
    logic [DW-1:0] bd [8];
    logic [DW-1:0] bexp [8];
    int            hs_t, rsp_t, prev_rsp;

    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.rsp_ready  = 1'b1;
    bus0.req_valid = 1'b0;
    bus0.req_write = 1'b0;
    bus0.req_addr  = '0;
    bus0.req_wdata = '0;
    bus0.rsp_ready = 1'b1;

    // Reset: all outputs low while asserted, req_ready one edge after release.
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_rsp_error", bus.rsp_error, 0);
    chk("rst_req_ready0", bus0.req_ready, 0);
    rst = 1'b0;
    chk("ready_before_edge", bus.req_ready, 0);
    tick();
    chk("ready_after_release", bus.req_ready, 1);

    do_txn(1'b0, 4'd5, 32'h0, rd, er, lat);
    chk("rd5_after_rst", rd, 0);
    chk("rd5_err", er, 0);
    chk("rd5_lat", lat, 4);

    // Write then read back with latency checks.
    do_txn(1'b1, 4'd3, 32'hDEADBEEF, rd, er, lat);
    chk("wr3_lat", lat, 4);
    chk("wr3_rdata", rd, 0);
    chk("wr3_err", er, 0);
    do_txn(1'b0, 4'd3, 32'h0, rd, er, lat);
    chk("rd3_lat", lat, 4);
    chk("rd3_rdata", rd, 32'hDEADBEEF);
    chk("rd3_err", er, 0);

    // Backpressure: response held for 10 cycles with rsp_ready low.
    bus.rsp_ready = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 4'd3;
    bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      tick();
      n++;
    end
    tick();
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      tick();
      n++;
    end
    chk("bp_rsp_valid", bus.rsp_valid, 1);
    hold_d = bus.rsp_rdata;
    hold_e = bus.rsp_error;
    chk("bp_rdata", hold_d, 32'hDEADBEEF);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold_valid", bus.rsp_valid, 1);
      chk("bp_hold_rdata", bus.rsp_rdata, hold_d);
      chk("bp_hold_error", bus.rsp_error, hold_e);
      chk("bp_no_ready", bus.req_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    chk("bp_release_valid", bus.rsp_valid, 0);
    chk("bp_release_ready", bus.req_ready, 1);

    // Out-of-range accesses must not disturb in-range contents.
    do_txn(1'b1, 4'd1, 32'hA5A5A5A5, rd, er, lat);
    do_txn(1'b1, 4'd13, 32'h1234, rd, er, lat);
    chk("oor_wr_rdata", rd, 0);
    chk("oor_wr_err", er, ERR_EXP);
    chk("oor_wr_lat", lat, 4);
    do_txn(1'b0, 4'd13, 32'h0, rd, er, lat);
    chk("oor_rd_rdata", rd, 0);
    chk("oor_rd_err", er, ERR_EXP);
    chk("oor_rd_lat", lat, 4);
    do_txn(1'b0, 4'd1, 32'h0, rd, er, lat);
    chk("addr1_intact", rd, 32'hA5A5A5A5);
    chk("addr1_err", er, 0);

    // Reset during WAIT: write lost, no response.
    bus.req_write = 1'b1;
    bus.req_addr  = 4'd2;
    bus.req_wdata = 32'h55;
    bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      tick();
      n++;
    end
    tick();
    bus.req_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_valid", bus.rsp_valid, 0);
    chk("midrst_ready", bus.req_ready, 0);
    tick();
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.rsp_valid) seen = 1'b1;
    end
    chk("midrst_no_rsp", seen, 0);
    do_txn(1'b0, 4'd2, 32'h0, rd, er, lat);
    chk("midrst_rd2", rd, 0);
    do_txn(1'b0, 4'd3, 32'h0, rd, er, lat);
    chk("midrst_rd3_cleared", rd, 0);

    // Back-to-back on the WAIT_CYCLES=0 instance: req_valid and rsp_ready held high.
    for (int i = 0; i < 4; i++) begin
      bw[i]       = 1'b1;
      ba[i]       = 4'(i + 4);
      bd[i]       = 32'h100 + 32'(i);
      bexp[i]     = 32'h0;
      bw[i+4]     = 1'b0;
      ba[i+4]     = 4'(i + 4);
      bd[i+4]     = 32'h0;
      bexp[i+4]   = 32'h100 + 32'(i);
    end
    bus0.rsp_ready = 1'b1;
    bus0.req_write = bw[0];
    bus0.req_addr  = ba[0];
    bus0.req_wdata = bd[0];
    bus0.req_valid = 1'b1;
    prev_rsp = 0;
    for (int i = 0; i < 8; i++) begin
      n = 0;
      while (!bus0.req_ready && n < 50) begin
        tick();
        n++;
      end
      tick();
      hs_t = cyc;
      if (i < 7) begin
        bus0.req_write = bw[i+1];
        bus0.req_addr  = ba[i+1];
        bus0.req_wdata = bd[i+1];
      end else begin
        bus0.req_valid = 1'b0;
      end
      n = 0;
      while (!bus0.rsp_valid && n < 50) begin
        tick();
        n++;
      end
      rsp_t = cyc;
      chk("b2b_rdata", bus0.rsp_rdata, bexp[i]);
      chk("b2b_lat", rsp_t - hs_t, 2);
      if (i > 0) chk("b2b_period", rsp_t - prev_rsp, 4);
      prev_rsp = rsp_t;
      tick();
      chk("b2b_one_cycle", bus0.rsp_valid, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
